// File: rtl/mem_1rw_masked.sv
// mem_1rw_masked: parametrised single-port (1RW) synchronous RAM with a
// per-byte write mask, a valid/ready request/response handshake with
// response backpressure, and a zero-fill sweep after every reset.
//
// Optional build macro MEM_OUT_REG_EN: adds an output register after the
// array read. Read latency becomes 2 cycles and only one read is ever in
// flight. When the macro is undefined, read latency is 1 cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | zero-fill sweep, one word per cycle; requests are refused
// ST_RUN  | normal operation; requests accepted when req_ready is high

module mem_1rw_masked #(
   parameter  int DATA_W = 64,
   parameter  int DEPTH  = 32,
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int MASK_W = DATA_W / 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [MASK_W-1:0] req_wmask,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              init_done
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic [ADDR_W-1:0] init_cnt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              in_range;
   logic              accept;
   logic              rd_accept;
   logic              wr_accept;
   logic [DATA_W-1:0] rd_word;

   // Addresses past the end of a non-power-of-two array are legal on the
   // bus: writes to them are dropped and reads of them return zero.
   assign in_range  = ({1'b0, req_addr} < DEPTH_EXT);
   assign accept    = req_valid & req_ready;
   assign rd_accept = accept & ~req_we;
   assign wr_accept = accept & req_we & in_range;
   assign rd_word   = in_range ? mem[req_addr] : '0;

   // Sequencer: sweep every word once after reset, then stay in RUN.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_INIT;
         init_cnt  <= '0;
         init_done <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               if (init_cnt == LAST_IDX) begin
                  state     <= ST_RUN;
                  init_cnt  <= '0;
                  init_done <= 1'b1;
               end else begin
                  init_cnt <= init_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               state     <= ST_RUN;
               init_done <= 1'b1;
            end
            default: begin
               state     <= ST_INIT;
               init_cnt  <= '0;
               init_done <= 1'b0;
            end
         endcase
      end
   end

   // Storage array: no reset of its own; cleared by the sweep, then
   // updated byte-by-byte under the write mask.
   always_ff @(posedge clock) begin
      if (state == ST_INIT) begin
         mem[init_cnt] <= '0;
      end else if (wr_accept) begin
         for (int i = 0; i < MASK_W; i++) begin
            if (req_wmask[i]) begin
               mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
            end
         end
      end
   end

`ifdef MEM_OUT_REG_EN

   logic              s1_valid;
   logic [DATA_W-1:0] s1_data;

   // One read outstanding: nothing new while the extra stage or a stalled
   // response is still occupied.
   assign req_ready = (state == ST_RUN) & ~s1_valid & (~rsp_valid | rsp_ready);

   // Extra stage: captures the array word at accept, drains into the
   // response register as soon as that register is free.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else if (rd_accept) begin
         s1_valid <= 1'b1;
         s1_data  <= rd_word;
      end else if (s1_valid & (~rsp_valid | rsp_ready)) begin
         s1_valid <= 1'b0;
      end
   end

   // Response register: holds under backpressure, keeps last data when idle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else if (~rsp_valid | rsp_ready) begin
         rsp_valid <= s1_valid;
         if (s1_valid) begin
            rsp_data <= s1_data;
         end
      end
   end

`else

   // Writes also wait behind an unconsumed response, keeping the port
   // strictly in order.
   assign req_ready = (state == ST_RUN) & (~rsp_valid | rsp_ready);

   // Response register: loads on read accept, holds under backpressure,
   // keeps last data when idle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else if (rd_accept) begin
         rsp_valid <= 1'b1;
         rsp_data  <= rd_word;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

`endif

endmodule

// File: tb/tb_mem_1rw_masked.sv
// tb_mem_1rw_masked: drives a DEPTH=32 and a DEPTH=20 instance with the same
// request stream; a byte-masked model per instance predicts read data, which
// is queued at accept and compared when each response handshake completes.

module tb_mem_1rw_masked;

   logic        clock = 1'b0;
   logic        rst   = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we    = 1'b0;
   logic [4:0]  req_addr  = '0;
   logic [63:0] req_wdata = '0;
   logic [7:0]  req_wmask = '0;
   logic        rsp_ready = 1'b1;

   logic        rdy32, rv32, done32;
   logic [63:0] rd32;
   logic        rdy20, rv20, done20;
   logic [63:0] rd20;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          last_run = 0;

   logic [63:0] m32 [32];
   logic [63:0] m20 [20];
   logic [63:0] q32 [$];
   logic [63:0] q20 [$];

   mem_1rw_masked #(.DATA_W(64), .DEPTH(32)) u_mem32 (
      .clock     (clock),
      .reset     (rst),
      .req_valid (req_valid),
      .req_ready (rdy32),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wmask (req_wmask),
      .rsp_valid (rv32),
      .rsp_ready (rsp_ready),
      .rsp_data  (rd32),
      .init_done (done32)
   );

   mem_1rw_masked #(.DATA_W(64), .DEPTH(20)) u_mem20 (
      .clock     (clock),
      .reset     (rst),
      .req_valid (req_valid),
      .req_ready (rdy20),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wmask (req_wmask),
      .rsp_valid (rv20),
      .rsp_ready (rsp_ready),
      .rsp_data  (rd20),
      .init_done (done20)
   );

   initial forever #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Response monitor, sampled mid-low-phase.
   task automatic monitor();
      int run = 0;
      forever begin
         @(negedge clock);
         #2;
         if (rv32) run++;
         else begin
            if (run != 0) last_run = run;
            run = 0;
         end
         if (rv32 && rsp_ready) begin
            if (q32.size() == 0) chk("rsp32_unexpected", 64'd1, 64'd0);
            else chk("rsp32_data", rd32, q32.pop_front());
         end
         if (rv20 && rsp_ready) begin
            if (q20.size() == 0) chk("rsp20_unexpected", 64'd1, 64'd0);
            else chk("rsp20_data", rd20, q20.pop_front());
         end
      end
   endtask

   // Present a request at a falling edge; returns at the accepting rising edge.
   task automatic do_req(input logic we, input logic [4:0] a,
                         input logic [63:0] d, input logic [7:0] m);
      int n = 0;
      @(negedge clock);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m;
      #1;
      while (!rdy32 && n < 50) begin
         @(negedge clock); #1; n++;
      end
      if (!rdy32) begin
         chk("req_timeout", 64'd0, 64'd1);
         req_valid = 1'b0;
         return;
      end
      if (we) begin
         for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
               m32[a][8*i +: 8] = d[8*i +: 8];
               if (a < 20) m20[a][8*i +: 8] = d[8*i +: 8];
            end
         end
      end else begin
         q32.push_back(m32[a]);
         if (a < 20) q20.push_back(m20[a]);
         else q20.push_back(64'd0);
      end
      @(posedge clock);
   endtask

   task automatic idle(input int n);
      @(negedge clock);
      req_valid = 1'b0;
      repeat (n - 1) @(negedge clock);
   endtask

   task automatic wait_rv();
      int n = 0;
      while (!rv32 && n < 10) begin
         @(posedge clock); #1; n++;
      end
      chk("rsp_wait", rv32, 1'b1);
   endtask

   task automatic do_reset();
      int c32 = 0, c20 = 0, r32 = 0;
      @(negedge clock);
      rst = 1'b0;
      req_valid = 1'b0;
      #1;
      chk("rst_rsp_valid32", rv32, 1'b0);
      chk("rst_rsp_valid20", rv20, 1'b0);
      chk("rst_req_ready", rdy32, 1'b0);
      chk("rst_init_done", done32, 1'b0);
      chk("rst_rsp_data", rd32, 64'd0);
      q32.delete();
      q20.delete();
      for (int i = 0; i < 32; i++) m32[i] = '0;
      for (int i = 0; i < 20; i++) m20[i] = '0;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clock);
      rst = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clock); #1;
         if (done32 && c32 == 0) c32 = k;
         if (done20 && c20 == 0) c20 = k;
         if (rdy32 && r32 == 0) r32 = k;
         if (c32 != 0 && c20 != 0) break;
      end
      chk("init32_cycles", c32, 32);
      chk("init20_cycles", c20, 20);
      chk("ready32_cycles", r32, 32);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      fork
         monitor();
      join_none

      do_reset();

      // Fresh memory reads zero; check latency.
      do_req(1'b0, 5'd5, 64'd0, 8'd0);
      #1;
      req_valid = 1'b0;
`ifdef MEM_OUT_REG_EN
      chk("lat_early", rv32, 1'b0);
      @(posedge clock); #1;
`endif
      chk("lat", rv32, 1'b1);
      idle(2);

      // Byte mask merge, then an all-zero-mask write that must change nothing.
      do_req(1'b1, 5'd3, 64'h1122334455667788, 8'hFF);
      do_req(1'b1, 5'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
      do_req(1'b0, 5'd3, 64'd0, 8'd0);
      idle(3);
      chk("mask_merge", rd32, 64'h11223344AAAAAAAA);
      do_req(1'b1, 5'd3, 64'hFFFFFFFFFFFFFFFF, 8'h00);
      do_req(1'b0, 5'd3, 64'd0, 8'd0);
      idle(3);
      chk("mask_zero", rd32, 64'h11223344AAAAAAAA);

      // Back-to-back reads.
      do_req(1'b1, 5'd0, 64'h0000000000000A00, 8'hFF);
      do_req(1'b1, 5'd1, 64'h00000000000B0B01, 8'hFF);
      do_req(1'b1, 5'd2, 64'hC0000000000C0C02, 8'hFF);
      do_req(1'b0, 5'd0, 64'd0, 8'd0);
      do_req(1'b0, 5'd1, 64'd0, 8'd0);
      do_req(1'b0, 5'd2, 64'd0, 8'd0);
      idle(3);
`ifdef MEM_OUT_REG_EN
      chk("b2b_run", last_run, 1);
`else
      chk("b2b_run", last_run, 3);
`endif

      // Response backpressure.
      do_req(1'b1, 5'd7, 64'h0707070712345678, 8'hFF);
      idle(1);
      rsp_ready = 1'b0;
      do_req(1'b0, 5'd7, 64'd0, 8'd0);
      #1;
      req_valid = 1'b0;
      wait_rv();
      for (int i = 0; i < 4; i++) begin
         @(negedge clock); #2;
         chk("bp_valid", rv32, 1'b1);
         chk("bp_data", rd32, 64'h0707070712345678);
         chk("bp_ready", rdy32, 1'b0);
      end
      @(negedge clock);
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", rdy32, 1'b1);
      idle(2);

      // Out-of-range address on the 20-word instance.
      do_req(1'b1, 5'd19, 64'h1919191919191919, 8'hFF);
      do_req(1'b1, 5'd25, 64'h000000000000FFFF, 8'hFF);
      do_req(1'b0, 5'd25, 64'd0, 8'd0);
      idle(3);
      chk("oor_read20", rd20, 64'd0);
      chk("oor_read32", rd32, 64'h000000000000FFFF);
      do_req(1'b0, 5'd19, 64'd0, 8'd0);
      idle(3);
      chk("addr19_kept", rd20, 64'h1919191919191919);

      // Reset with a response pending.
      do_req(1'b1, 5'd1, 64'h000000000000DEAD, 8'hFF);
      idle(1);
      rsp_ready = 1'b0;
      do_req(1'b0, 5'd1, 64'd0, 8'd0);
      #1;
      req_valid = 1'b0;
      wait_rv();
      do_reset();
      do_req(1'b1, 5'd2, 64'h2222222222222222, 8'hFF);
      do_req(1'b0, 5'd2, 64'd0, 8'd0);
      do_req(1'b0, 5'd1, 64'd0, 8'd0);
      idle(4);
      chk("post_reset_read1", rd32, 64'd0);

      chk("q32_drained", q32.size(), 0);
      chk("q20_drained", q20.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
